// File: rtl/fade_sequencer.sv
// RGB colour-wheel fade sequencer: six hue phases, one channel ramping per phase,
// publishing registered per-channel PWM duty values.
module fade_sequencer #(
    parameter int unsigned PWM_INTERVAL     = 1200,
    parameter int unsigned INC_DEC_MAX      = 200,
    parameter int unsigned INC_DEC_INTERVAL = 10000,
    localparam int unsigned DUTY_W          = $clog2(PWM_INTERVAL + 1),
    localparam int unsigned LVL_W           = $clog2(INC_DEC_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              restart,
    output logic [DUTY_W-1:0] duty_r,
    output logic [DUTY_W-1:0] duty_g,
    output logic [DUTY_W-1:0] duty_b,
    output logic [2:0]        phase,
    output logic              step_tick,
    output logic              wrap
);

    localparam int unsigned DUTY_STEP = PWM_INTERVAL / INC_DEC_MAX;
    localparam int unsigned PS_W      = (INC_DEC_INTERVAL > 1) ? $clog2(INC_DEC_INTERVAL) : 1;

    localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(INC_DEC_INTERVAL - 1);
    localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(INC_DEC_MAX);
    localparam logic [LVL_W-1:0]  STEP_LAST = LVL_W'(INC_DEC_MAX - 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(PWM_INTERVAL);

    if (INC_DEC_INTERVAL < 1) begin : g_bad_interval
        $error("fade_sequencer: INC_DEC_INTERVAL must be >= 1");
    end
    if ((PWM_INTERVAL % INC_DEC_MAX) != 0) begin : g_bad_step
        $error("fade_sequencer: PWM_INTERVAL must be a multiple of INC_DEC_MAX");
    end

    // Enumerator names give the channel that ramps and its direction in that phase.
    typedef enum logic [2:0] {
        PhGUp   = 3'd0,
        PhRDown = 3'd1,
        PhBUp   = 3'd2,
        PhGDown = 3'd3,
        PhRUp   = 3'd4,
        PhBDown = 3'd5
    } phase_e;

    phase_e            phase_q, phase_d;
    logic [PS_W-1:0]   prescaler_q, prescaler_d;
    logic [LVL_W-1:0]  step_cnt_q, step_cnt_d;
    logic [LVL_W-1:0]  lvl_r_q, lvl_r_d, lvl_g_q, lvl_g_d, lvl_b_q, lvl_b_d;
    logic [DUTY_W-1:0] duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;

    function automatic logic [LVL_W-1:0] lvl_up(input logic [LVL_W-1:0] l);
        return (l >= LVL_MAX) ? LVL_MAX : l + 1'b1;
    endfunction

    function automatic logic [LVL_W-1:0] lvl_dn(input logic [LVL_W-1:0] l);
        return (l == '0) ? '0 : l - 1'b1;
    endfunction

    function automatic logic [DUTY_W-1:0] scale(input logic [LVL_W-1:0] l);
        return DUTY_W'(32'(l) * DUTY_STEP);
    endfunction

    always_comb begin
        phase_d     = phase_q;
        prescaler_d = prescaler_q;
        step_cnt_d  = step_cnt_q;
        lvl_r_d     = lvl_r_q;
        lvl_g_d     = lvl_g_q;
        lvl_b_d     = lvl_b_q;

        step_tick = en & ~restart & (prescaler_q == PS_LAST);
        wrap      = step_tick & (phase_q == PhBDown) & (step_cnt_q == STEP_LAST);

        if (restart) begin
            phase_d     = PhGUp;
            prescaler_d = '0;
            step_cnt_d  = '0;
            lvl_r_d     = LVL_MAX;
            lvl_g_d     = '0;
            lvl_b_d     = '0;
        end else if (en) begin
            prescaler_d = (prescaler_q == PS_LAST) ? '0 : prescaler_q + 1'b1;
            if (step_tick) begin
                case (phase_q)
                    PhGUp:   lvl_g_d = lvl_up(lvl_g_q);
                    PhRDown: lvl_r_d = lvl_dn(lvl_r_q);
                    PhBUp:   lvl_b_d = lvl_up(lvl_b_q);
                    PhGDown: lvl_g_d = lvl_dn(lvl_g_q);
                    PhRUp:   lvl_r_d = lvl_up(lvl_r_q);
                    PhBDown: lvl_b_d = lvl_dn(lvl_b_q);
                    default: ;
                endcase
                if (step_cnt_q == STEP_LAST) begin
                    step_cnt_d = '0;
                    phase_d    = (phase_q == PhBDown) ? PhGUp : phase_e'(phase_q + 3'd1);
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end
        end

        // Duty follows the next level so it lands on the same edge as the level change.
        duty_r_d = scale(lvl_r_d);
        duty_g_d = scale(lvl_g_d);
        duty_b_d = scale(lvl_b_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= PhGUp;
            prescaler_q <= '0;
            step_cnt_q  <= '0;
            lvl_r_q     <= LVL_MAX;
            lvl_g_q     <= '0;
            lvl_b_q     <= '0;
            duty_r_q    <= DUTY_MAX;
            duty_g_q    <= '0;
            duty_b_q    <= '0;
        end else begin
            phase_q     <= phase_d;
            prescaler_q <= prescaler_d;
            step_cnt_q  <= step_cnt_d;
            lvl_r_q     <= lvl_r_d;
            lvl_g_q     <= lvl_g_d;
            lvl_b_q     <= lvl_b_d;
            duty_r_q    <= duty_r_d;
            duty_g_q    <= duty_g_d;
            duty_b_q    <= duty_b_d;
        end
    end

    assign duty_r = duty_r_q;
    assign duty_g = duty_g_q;
    assign duty_b = duty_b_q;
    assign phase  = phase_q;

endmodule

// File: tb/tb_fade_sequencer.sv
// Bench for fade_sequencer: outputs are derived from the count of enabled clocks since
// reset, compared every cycle, plus hand-computed checkpoints.
module tb_fade_sequencer;

    localparam int unsigned PI = 12;
    localparam int unsigned M  = 4;
    localparam int unsigned IV = 5;
    localparam int unsigned DS = 3;
    localparam int unsigned DW = $clog2(PI + 1);

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          en      = 1'b0;
    logic          restart = 1'b0;
    logic [DW-1:0] duty_r, duty_g, duty_b;
    logic [2:0]    phase;
    logic          step_tick, wrap;

    int checks   = 0;
    int errors   = 0;
    int n        = 0;  // enabled clocks since last reset/restart
    int wrap_cnt = 0;

    fade_sequencer #(
        .PWM_INTERVAL    (PI),
        .INC_DEC_MAX     (M),
        .INC_DEC_INTERVAL(IV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .restart  (restart),
        .duty_r   (duty_r),
        .duty_g   (duty_g),
        .duty_b   (duty_b),
        .phase    (phase),
        .step_tick(step_tick),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_k(input int nn);
        return nn / IV;
    endfunction

    function automatic int m_phase(input int nn);
        return (m_k(nn) / M) % 6;
    endfunction

    // Levels from the hue table: s = steps already taken inside the current phase.
    function automatic void m_lvl(input int nn, output int r, output int g, output int b);
        int s;
        s = m_k(nn) % M;
        case (m_phase(nn))
            0:       begin r = M;     g = s;     b = 0;     end
            1:       begin r = M - s; g = M;     b = 0;     end
            2:       begin r = 0;     g = M;     b = s;     end
            3:       begin r = 0;     g = M - s; b = M;     end
            4:       begin r = s;     g = 0;     b = M;     end
            default: begin r = M;     g = 0;     b = M - s; end
        endcase
    endfunction

    function automatic int m_tick(input int nn, input logic e, input logic rs);
        return (e && !rs && (nn % IV == IV - 1)) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       n <= 0;
        else if (restart) n <= 0;
        else if (en)      n <= n + 1;
    end

    int mr, mg, mb, mt, sum, changes;
    int prev_r, prev_g, prev_b, prev_tick;
    bit prev_valid = 1'b0;

    always @(negedge clk) begin
        m_lvl(n, mr, mg, mb);
        mt = m_tick(n, en, restart);
        chk("duty_r", duty_r, mr * DS);
        chk("duty_g", duty_g, mg * DS);
        chk("duty_b", duty_b, mb * DS);
        chk("phase", phase, m_phase(n));
        chk("step_tick", step_tick, mt);
        chk("wrap", wrap, (mt == 1 && (m_k(n) % (6 * M) == 6 * M - 1)) ? 1 : 0);
        sum = duty_r + duty_g + duty_b;
        chk("duty_sum_in_range", (sum >= PI && sum <= 2 * PI) ? 1 : 0, 1);
        if (prev_valid && prev_tick == 1 && rst_n) begin
            changes = (duty_r != prev_r) + (duty_g != prev_g) + (duty_b != prev_b);
            chk("one_channel_per_tick", changes, 1);
        end
        if (wrap) wrap_cnt++;
        prev_valid = rst_n;
        prev_tick  = step_tick;
        prev_r     = duty_r;
        prev_g     = duty_g;
        prev_b     = duty_b;
    end

    task automatic cycles(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        en = 1'b1;
        #1;
        chk("reset_duty_r", duty_r, 12);
        chk("reset_duty_g", duty_g, 0);
        chk("reset_duty_b", duty_b, 0);
        chk("reset_phase", phase, 0);
        chk("reset_tick", step_tick, 0);

        cycles(4);
        chk("first_tick_clk5", step_tick, 1);
        cycles(1);
        chk("duty_g_after_first_tick", duty_g, 3);
        cycles(15);
        chk("p0_end_duty_g", duty_g, 12);
        chk("p0_end_phase", phase, 1);
        cycles(20);
        chk("p1_end_duty_r", duty_r, 0);
        chk("p1_end_phase", phase, 2);
        cycles(80);
        chk("full_cycle_wraps", wrap_cnt, 1);
        chk("full_cycle_duty_r", duty_r, 12);
        chk("full_cycle_duty_g", duty_g, 0);
        chk("full_cycle_duty_b", duty_b, 0);
        chk("full_cycle_phase", phase, 0);

        // Park at prescaler=2 with a non-trivial green level, then freeze.
        cycles(7);
        en = 1'b0;
        cycles(7);
        chk("frozen_duty_g", duty_g, 3);
        chk("frozen_tick", step_tick, 0);
        en = 1'b1;
        cycles(1);
        chk("resume_no_tick_yet", step_tick, 0);
        cycles(1);
        chk("resume_tick_after_2", step_tick, 1);

        for (int i = 0; i < 400; i++) begin
            en = (($urandom % 4) != 0);
            cycles(1);
        end

        en = 1'b1;
        guard = 0;
        while (!(m_phase(n) == 3 && (n % IV) == IV - 1) && guard < 3000) begin
            cycles(1);
            guard++;
        end
        chk("reached_p3_tick", (guard < 3000) ? 1 : 0, 1);
        restart = 1'b1;
        #1;
        chk("restart_blocks_tick", step_tick, 0);
        cycles(1);
        restart = 1'b0;
        #1;
        chk("restart_duty_r", duty_r, 12);
        chk("restart_duty_g", duty_g, 0);
        chk("restart_duty_b", duty_b, 0);
        chk("restart_phase", phase, 0);

        guard = 0;
        while (!(m_phase(n) == 4 && (m_k(n) % M) == 2) && guard < 3000) begin
            cycles(1);
            guard++;
        end
        chk("reached_p4_mid", (guard < 3000) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_duty_r", duty_r, 12);
        chk("async_rst_duty_g", duty_g, 0);
        chk("async_rst_duty_b", duty_b, 0);
        chk("async_rst_phase", phase, 0);
        cycles(2);
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            en      = (($urandom % 4) != 0);
            restart = (($urandom % 64) == 0);
            cycles(1);
        end
        restart = 1'b0;
        en      = 1'b0;
        cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
